// File: rtl/stream_pkg.sv
// Shared helpers for the stream packer: counter width, lane offsets and keep masks.
package stream_pkg;

  localparam int unsigned MAX_RATIO = 16;

  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Bit offset of lane k in a packed word of dw-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned dw);
    return k * dw;
  endfunction

  // Mask with the n lowest lanes set; n >= MAX_RATIO gives all ones.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned n);
    if (n >= MAX_RATIO) return '1;
    return (MAX_RATIO'(1) << n) - MAX_RATIO'(1);
  endfunction

endpackage

// File: rtl/packer_lane_ctrl.sv
// Lane counter, pending-flush flag and in_ready/load decode for stream_packer.
// Flush support is built only when STREAM_PACKER_FLUSH_EN is defined.
module packer_lane_ctrl
  import stream_pkg::*;
#(
  parameter int unsigned RATIO = 4,
  parameter int unsigned CNT_W = cnt_width(RATIO)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic             out_valid,
  input  logic             out_ready,
`ifdef STREAM_PACKER_FLUSH_EN
  input  logic             flush,
  output logic             flush_emit,
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             in_ready,
  output logic             acc_we,
  output logic             full_load,
  output logic [CNT_W-1:0] wr_lane
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last, slot_free, in_fire, emit;

`ifdef STREAM_PACKER_FLUSH_EN
  logic pending_q, pending_d;
  assign flush_emit = emit;
  assign cnt        = cnt_q;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d     = cnt_q;
    last      = (cnt_q == LAST);
    slot_free = ~out_valid | out_ready;
`ifdef STREAM_PACKER_FLUSH_EN
    pending_d = pending_q;
    emit      = pending_q & slot_free;
    in_ready  = (~last | slot_free) & ~(pending_q & ~slot_free);
`else
    emit      = 1'b0;
    in_ready  = ~last | slot_free;
`endif
    in_fire   = in_valid & in_ready;
    // While a partial word is emitted, a new word starts the next group in lane 0.
    full_load = in_fire & last & ~emit;
    acc_we    = in_fire & (emit | ~last);
    wr_lane   = emit ? '0 : cnt_q;

    if (emit)         cnt_d = in_fire ? CNT_W'(1) : '0;
    else if (in_fire) cnt_d = last ? '0 : cnt_q + CNT_W'(1);

`ifdef STREAM_PACKER_FLUSH_EN
    if (emit) pending_d = flush & in_fire;
    else if (flush & ((cnt_q != '0) | in_fire) & ~(in_fire & last)) pending_d = 1'b1;
`endif
  end

  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (areset) begin
      cnt_q <= '0;
`ifdef STREAM_PACKER_FLUSH_EN
      pending_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
`ifdef STREAM_PACKER_FLUSH_EN
      pending_q <= pending_d;
`endif
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO consecutive DATA_WIDTH words into one wide word, first word in lane 0.
// Define STREAM_PACKER_FLUSH_EN to add flush/out_keep for emitting partial words.
module stream_packer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic                        out_valid,
`ifdef STREAM_PACKER_FLUSH_EN
  input  logic                        flush,
  output logic [RATIO-1:0]            out_keep,
`endif
  input  logic                        out_ready
);

  localparam int unsigned CNT_W = cnt_width(RATIO);
  localparam int unsigned ACC_W = DATA_WIDTH * (RATIO - 1);

  logic [ACC_W-1:0] acc;
  logic             acc_we, full_load;
  logic [CNT_W-1:0] wr_lane;

`ifdef STREAM_PACKER_FLUSH_EN
  logic                        flush_emit;
  logic [CNT_W-1:0]            cnt;
  logic [DATA_WIDTH*RATIO-1:0] partial;
`endif

  packer_lane_ctrl #(.RATIO(RATIO), .CNT_W(CNT_W)) u_ctrl (
    .aclk       (aclk),
    .areset     (areset),
    .in_valid   (in_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef STREAM_PACKER_FLUSH_EN
    .flush      (flush),
    .flush_emit (flush_emit),
    .cnt        (cnt),
`endif
    .in_ready   (in_ready),
    .acc_we     (acc_we),
    .full_load  (full_load),
    .wr_lane    (wr_lane)
  );

`ifdef STREAM_PACKER_FLUSH_EN
  // Lanes at or above cnt hold stale data from an earlier group and are zeroed.
  always_comb begin
    partial = '0;
    for (int k = 0; k < int'(RATIO) - 1; k++) begin
      if (CNT_W'(k) < cnt)
        partial[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = acc[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      // NOTE: the accumulator is reset too, so a discarded partial word can never leak out.
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
      out_keep  <= '0;
`endif
    end else begin
      for (int k = 0; k < int'(RATIO) - 1; k++) begin
        if (acc_we && wr_lane == CNT_W'(k))
          acc[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] <= in_data;
      end

      if (full_load) begin
        out_data  <= {in_data, acc};
        out_valid <= 1'b1;
`ifdef STREAM_PACKER_FLUSH_EN
        out_keep  <= '1;
      end else if (flush_emit) begin
        out_data  <= partial;
        out_valid <= 1'b1;
        out_keep  <= RATIO'(keep_mask(32'(cnt)));
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: table-driven groups plus hand-written
// backpressure, reset and (with STREAM_PACKER_FLUSH_EN) flush sequences.
module tb_stream_packer;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int OW = DW * R;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef STREAM_PACKER_FLUSH_EN
  logic          flush = 1'b0;
  logic [R-1:0]  out_keep;
`endif

  stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef STREAM_PACKER_FLUSH_EN
    .flush     (flush),
    .out_keep  (out_keep),
`endif
    .out_ready (out_ready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_check = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [DW-1:0] w [R];
    logic [OW-1:0] res;
  } vec_t;

  exp_t sb [$];
  exp_t e;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void push_exp(input logic [OW-1:0] d, input logic [R-1:0] k);
    sb.push_back('{data: d, keep: k, cyc: cyc});
  endfunction

  // Called at a falling edge; returns at the falling edge after the word is accepted.
  task automatic send(input logic [DW-1:0] w, input bit chk_rdy, input bit push,
                      input logic [OW-1:0] res, input logic [R-1:0] keep);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    #1;
    if (chk_rdy) check("in_ready_hi", OW'(in_ready), OW'(1));
    while (!in_ready && t < 50) begin
      @(negedge aclk);
      #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end else if (push) begin
      push_exp(res, keep);
    end
    @(negedge aclk);
  endtask

  // Output monitor: pops the scoreboard on every out_fire, checks stability under backpressure.
  logic [OW-1:0] held;
  bit            held_v = 1'b0;
  initial forever begin
    @(negedge aclk);
    #2;
    if (!areset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no output", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
`ifdef STREAM_PACKER_FLUSH_EN
        check("out_keep", OW'(out_keep), OW'(e.keep));
`endif
        if (lat_check) check("latency", OW'(cyc), OW'(e.cyc + 1));
      end
      held_v = 1'b0;
    end else if (!areset && out_valid) begin
      if (held_v) check("hold_stable", out_data, held);
      held   = out_data;
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
  end

  vec_t tbl [4];

  initial begin
    tbl[0] = '{w: '{32'h1, 32'h2, 32'h3, 32'h4},
               res: 128'h00000004_00000003_00000002_00000001};
    tbl[1] = '{w: '{32'h5, 32'h6, 32'h7, 32'h8},
               res: 128'h00000008_00000007_00000006_00000005};
    tbl[2] = '{w: '{32'hffffffff, 32'h0, 32'ha5a5a5a5, 32'h5a5a5a5a},
               res: 128'h5a5a5a5a_a5a5a5a5_00000000_ffffffff};
    tbl[3] = '{w: '{32'hdeadbeef, 32'h12345678, 32'h0, 32'h1},
               res: 128'h00000001_00000000_12345678_deadbeef};

    // Reset state
    areset    = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", OW'(in_ready), OW'(1));
    @(negedge aclk);

    // Back-to-back groups, no backpressure, one-cycle latency
    lat_check = 1'b1;
    foreach (tbl[v]) begin
      for (int i = 0; i < R; i++)
        send(tbl[v].w[i], 1'b1, i == R - 1, tbl[v].res, '1);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge aclk);
    lat_check = 1'b0;

    // Backpressure: HOLD accepts 3 words, STALL at the 4th, then release with no bubble
    out_ready = 1'b0;
    send(32'h21, 1'b1, 1'b0, '0, '1);
    send(32'h22, 1'b1, 1'b0, '0, '1);
    send(32'h23, 1'b1, 1'b0, '0, '1);
    send(32'h24, 1'b1, 1'b1, 128'h00000024_00000023_00000022_00000021, '1);
    send(32'h31, 1'b1, 1'b0, '0, '1);
    send(32'h32, 1'b1, 1'b0, '0, '1);
    send(32'h33, 1'b1, 1'b0, '0, '1);
    in_data  = 32'h34;
    in_valid = 1'b1;
    #1;
    check("stall_in_ready", OW'(in_ready), OW'(0));
    repeat (3) begin
      @(negedge aclk);
      #1;
      check("stall_in_ready", OW'(in_ready), OW'(0));
    end
    @(negedge aclk);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", OW'(in_ready), OW'(1));
    push_exp(128'h00000034_00000033_00000032_00000031, '1);
    @(negedge aclk);
    in_valid = 1'b0;
    #1;
    check("no_gap_valid", OW'(out_valid), OW'(1));
    check("no_gap_data", out_data, 128'h00000034_00000033_00000032_00000031);
    repeat (3) @(negedge aclk);

    // Reset in the middle of a group discards the partial words
    send(32'h41, 1'b1, 1'b0, '0, '1);
    send(32'h42, 1'b1, 1'b0, '0, '1);
    in_valid = 1'b0;
    areset   = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("midrst_out_valid", OW'(out_valid), OW'(0));
    check("midrst_in_ready", OW'(in_ready), OW'(1));
    @(negedge aclk);
    send(32'ha, 1'b1, 1'b0, '0, '1);
    send(32'hb, 1'b1, 1'b0, '0, '1);
    send(32'hc, 1'b1, 1'b0, '0, '1);
    send(32'hd, 1'b1, 1'b1, 128'h0000000d_0000000c_0000000b_0000000a, '1);
    in_valid = 1'b0;
    repeat (3) @(negedge aclk);

`ifdef STREAM_PACKER_FLUSH_EN
    // Partial flush of two words, then a flush with nothing buffered
    send(32'h11, 1'b1, 1'b0, '0, '1);
    send(32'h22, 1'b1, 1'b0, '0, '1);
    in_valid = 1'b0;
    flush    = 1'b1;
    push_exp(128'h00000000_00000000_00000022_00000011, 4'b0011);
    @(negedge aclk);
    flush = 1'b0;
    repeat (4) @(negedge aclk);
    flush = 1'b1;
    @(negedge aclk);
    flush = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      #1;
      check("flush_empty", OW'(out_valid), OW'(0));
    end
    @(negedge aclk);

    // Flush while the output slot is blocked: partial word goes out before new input
    out_ready = 1'b0;
    send(32'h51, 1'b1, 1'b0, '0, '1);
    send(32'h52, 1'b1, 1'b0, '0, '1);
    send(32'h53, 1'b1, 1'b0, '0, '1);
    send(32'h54, 1'b1, 1'b1, 128'h00000054_00000053_00000052_00000051, '1);
    send(32'h61, 1'b1, 1'b0, '0, '1);
    in_valid = 1'b0;
    flush    = 1'b1;
    push_exp(128'h00000000_00000000_00000000_00000061, 4'b0001);
    @(negedge aclk);
    flush    = 1'b0;
    in_data  = 32'h71;
    in_valid = 1'b1;
    #1;
    check("pend_in_ready", OW'(in_ready), OW'(0));
    repeat (2) begin
      @(negedge aclk);
      #1;
      check("pend_in_ready", OW'(in_ready), OW'(0));
    end
    @(negedge aclk);
    out_ready = 1'b1;
    #1;
    check("pend_release", OW'(in_ready), OW'(1));
    @(negedge aclk);
    send(32'h72, 1'b1, 1'b0, '0, '1);
    send(32'h73, 1'b1, 1'b0, '0, '1);
    send(32'h74, 1'b1, 1'b1, 128'h00000074_00000073_00000072_00000071, '1);
    in_valid = 1'b0;
`endif

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge aclk);
    repeat (2) @(negedge aclk);
    check("scoreboard_empty", OW'(sb.size()), OW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
